// File: rtl/mux_arb_n_1.sv
// N-input registered mux with valid/ready on every port.
// Channels are picked either directly (sel) or by round-robin arbitration.
module mux_arb_n_1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_src;
    logic             r_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic [SEL_W-1:0] w_rr_cand;
    logic [SEL_W-1:0] w_cand;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_xfer;

    assign w_load_en = !r_valid || out_ready;

    // Scan from the far end back toward rr_ptr so the nearest valid channel
    // wins; SEL_W-bit addition gives the mod-NUM_IN wrap for free.
    always_comb begin
        logic [SEL_W-1:0] idx;
        w_rr_cand = r_rr_ptr;
        idx       = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = r_rr_ptr + SEL_W'(k);
            if (in_valid[idx]) w_rr_cand = idx;
        end
    end

    assign w_cand      = mode ? w_rr_cand : sel;
    assign w_cand_data = in_data[w_cand*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = rst && w_load_en && (w_cand == SEL_W'(i));
        end
    end

    assign w_xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_load_en) begin
                r_valid <= w_xfer;
                if (w_xfer) begin
                    r_data <= w_cand_data;
                    r_src  <= w_cand;
                end
            end
            if (mode && w_xfer) r_rr_ptr <= w_cand + SEL_W'(1);
        end
    end

    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_arb_n_1.sv
// Directed bench for mux_arb_n_1 (WIDTH=8, NUM_IN=4) with hand-computed expectations.
module tb_mux_arb_n_1;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;

    int n_chk;
    int n_err;

    mux_arb_n_1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".src"},   32'(out_src),   32'(s));
    endtask

    logic [7:0] rr_exp [0:4];

    initial begin
        n_chk = 0;
        n_err = 0;
        rr_exp[0] = 8'h10; rr_exp[1] = 8'h20; rr_exp[2] = 8'h30;
        rr_exp[3] = 8'h40; rr_exp[4] = 8'h10;

        // Power-up reset: in_ready must stay low even with valid inputs.
        rst = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        in_data = '0; in_valid = 4'hF;
        #1;
        chk_out("por", 1'b0, 8'h00, 2'd0);
        chk("por.in_ready", 32'(in_ready), 32'h0);
        tick(); tick();
        #2 rst = 1'b1;

        // Load 0x3C on ch0 and hold it under backpressure.
        in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
        in_valid = 4'b0001;
        #1;
        chk("ld.in_ready", 32'(in_ready), 32'b0001);
        tick();
        in_valid = 4'b0000;
        chk_out("ld", 1'b1, 8'h3C, 2'd0);
        tick();
        chk_out("ld.hold", 1'b1, 8'h3C, 2'd0);

        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        #1;
        chk_out("arst", 1'b0, 8'h00, 2'd0);
        chk("arst.in_ready", 32'(in_ready), 32'h0);
        #1 rst = 1'b1;
        tick();

        // Direct select with other channels also valid.
        in_data   = {8'h77, 8'hA5, 8'h11, 8'h01};
        in_valid  = 4'b0111;
        sel       = 2'd2;
        out_ready = 1'b1;
        #1;
        chk("dir.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("dir", 1'b1, 8'hA5, 2'd2);

        // Backpressure: a new selection must not disturb the held word.
        out_ready = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        #1;
        chk("bp.in_ready", 32'(in_ready), 32'b0000);
        tick();
        chk_out("bp.hold", 1'b1, 8'hA5, 2'd2);
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready2", 32'(in_ready), 32'b0010);
        tick();
        chk_out("bp.rel", 1'b1, 8'h11, 2'd1);

        // Invalid select: no fallback to other valid channels.
        sel      = 2'd3;
        in_valid = 4'b0111;
        #1;
        chk("inv.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("inv", 1'b0, 8'h11, 2'd1);

        // Round-robin, all valid; rr_ptr is still 0 after mode 0 and reset.
        mode     = 1'b1;
        in_data  = {8'h40, 8'h30, 8'h20, 8'h10};
        in_valid = 4'hF;
        #1;
        chk("rr.in_ready0", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rr%0d", k), 1'b1, rr_exp[k], 2'(k % 4));
        end
        // One more grant (ch1) moves rr_ptr to 2.
        tick();
        chk_out("rr5", 1'b1, 8'h20, 2'd1);

        // Sparse round-robin from rr_ptr=2.
        in_data  = {8'h77, 8'h00, 8'h55, 8'h00};
        in_valid = 4'b1010;
        #1;
        chk("sp.in_ready0", 32'(in_ready), 32'b1000);
        tick();
        chk_out("sp0", 1'b1, 8'h77, 2'd3);
        chk("sp.in_ready1", 32'(in_ready), 32'b0010);
        tick();
        chk_out("sp1", 1'b1, 8'h55, 2'd1);
        chk("sp.in_ready2", 32'(in_ready), 32'b1000);
        tick();
        chk_out("sp2", 1'b1, 8'h77, 2'd3);

        // Nothing valid in round-robin: ready points at rr_ptr (now 0), no transfer.
        in_valid = 4'b0000;
        #1;
        chk("idle.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("idle", 1'b0, 8'h77, 2'd3);

        // Mode switch keeps rr_ptr; a direct-mode transfer leaves it alone.
        mode     = 1'b0;
        sel      = 2'd2;
        in_data  = {8'h04, 8'h03, 8'h02, 8'h01};
        in_valid = 4'b0100;
        tick();
        chk_out("sw.dir", 1'b1, 8'h03, 2'd2);
        mode     = 1'b1;
        in_valid = 4'hF;
        #1;
        chk("sw.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("sw.rr", 1'b1, 8'h01, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
